// File: rtl/bout_controller.sv
// -----------------------------------------------------------------------------
// bout_controller
//   Sequences a fencing bout through IDLE -> COUNTDOWN -> FENCING -> LOCKOUT
//   and back to COUNTDOWN, or on to GAME_OVER. It counts touches per side,
//   applies the double-touch window and decides the winner.
//
// Ports
//   clk_pixel_in        : sole clock, rising edge
//   rst_in              : asynchronous active-low reset
//   start_in            : pulse, starts a bout from IDLE or GAME_OVER
//   abort_in            : pulse, returns to IDLE from any state (highest priority)
//   player_scored_in    : local touch, qualified by score_valid_in
//   opponent_scored_in  : remote touch, qualified by score_valid_in
//   score_valid_in      : strobe qualifying both scored inputs
//   phase_out           : 0 IDLE, 1 COUNTDOWN, 2 FENCING, 3 LOCKOUT, 4 GAME_OVER
//   fencing_en_out      : high in FENCING and LOCKOUT
//   countdown_out       : ticks remaining while in COUNTDOWN, else 0
//   round_start_out     : one-cycle pulse on each COUNTDOWN->FENCING transition
//   player_score_out    : local touch count (saturates at 15)
//   opponent_score_out  : remote touch count (saturates at 15)
//   winner_out          : 00 none, 01 player, 10 opponent, 11 tie
// -----------------------------------------------------------------------------
module bout_controller #(
  parameter int TICK_CYCLES     = 74_250_000,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int LOCKOUT_CYCLES  = 2_970_000,
  parameter int WIN_SCORE       = 5
) (
  input  logic       clk_pixel_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       abort_in,
  input  logic       player_scored_in,
  input  logic       opponent_scored_in,
  input  logic       score_valid_in,
  output logic [2:0] phase_out,
  output logic       fencing_en_out,
  output logic [1:0] countdown_out,
  output logic       round_start_out,
  output logic [3:0] player_score_out,
  output logic [3:0] opponent_score_out,
  output logic [1:0] winner_out
);

  // A parameter of 1 would give a zero-width counter; keep at least one bit.
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]        CD_LOAD   = 2'(COUNTDOWN_TICKS);
  localparam logic [3:0]        WIN_LVL   = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    FENCING   = 3'd2,
    LOCKOUT   = 3'd3,
    GAME_OVER = 3'd4
  } phase_t;

  phase_t            state_reg;
  logic [TICK_W-1:0] tick_cnt_reg;
  logic [LOCK_W-1:0] lock_cnt_reg;
  logic              player_hit_reg;    // player already scored this round
  logic              opponent_hit_reg;  // opponent already scored this round

  // Touch qualification and saturating next scores. In FENCING the hit flags
  // are clear, so the same terms serve both FENCING and LOCKOUT.
  logic       player_add;
  logic       opponent_add;
  logic [3:0] player_score_next;
  logic [3:0] opponent_score_next;
  logic       player_reached;
  logic       opponent_reached;

  always_comb begin
    player_add   = score_valid_in & player_scored_in &
                   ~((state_reg == LOCKOUT) & player_hit_reg);
    opponent_add = score_valid_in & opponent_scored_in &
                   ~((state_reg == LOCKOUT) & opponent_hit_reg);

    player_score_next = player_score_out;
    if (player_add && (player_score_out != 4'hF)) begin
      player_score_next = player_score_out + 4'd1;
    end

    opponent_score_next = opponent_score_out;
    if (opponent_add && (opponent_score_out != 4'hF)) begin
      opponent_score_next = opponent_score_out + 4'd1;
    end

    player_reached   = (player_score_next >= WIN_LVL);
    opponent_reached = (opponent_score_next >= WIN_LVL);
  end

  assign phase_out = state_reg;

  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg          <= IDLE;
      tick_cnt_reg       <= '0;
      lock_cnt_reg       <= '0;
      player_hit_reg     <= 1'b0;
      opponent_hit_reg   <= 1'b0;
      fencing_en_out     <= 1'b0;
      countdown_out      <= 2'd0;
      round_start_out    <= 1'b0;
      player_score_out   <= 4'd0;
      opponent_score_out <= 4'd0;
      winner_out         <= 2'b00;
    end else begin
      round_start_out <= 1'b0;

      if (abort_in) begin
        // Scores and winner stay visible; only the round machinery is cleared.
        state_reg        <= IDLE;
        tick_cnt_reg     <= '0;
        lock_cnt_reg     <= '0;
        player_hit_reg   <= 1'b0;
        opponent_hit_reg <= 1'b0;
        fencing_en_out   <= 1'b0;
        countdown_out    <= 2'd0;
      end else begin
        case (state_reg)
          IDLE, GAME_OVER: begin
            if (start_in) begin
              state_reg          <= COUNTDOWN;
              player_score_out   <= 4'd0;
              opponent_score_out <= 4'd0;
              winner_out         <= 2'b00;
              tick_cnt_reg       <= '0;
              countdown_out      <= CD_LOAD;
            end
          end

          COUNTDOWN: begin
            if (tick_cnt_reg == TICK_LAST) begin
              tick_cnt_reg <= '0;
              // The last tick goes straight to FENCING rather than showing 0.
              if (countdown_out <= 2'd1) begin
                state_reg        <= FENCING;
                countdown_out    <= 2'd0;
                fencing_en_out   <= 1'b1;
                round_start_out  <= 1'b1;
                player_hit_reg   <= 1'b0;
                opponent_hit_reg <= 1'b0;
              end else begin
                countdown_out <= countdown_out - 2'd1;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end

          FENCING: begin
            if (player_add || opponent_add) begin
              state_reg          <= LOCKOUT;
              player_score_out   <= player_score_next;
              opponent_score_out <= opponent_score_next;
              player_hit_reg     <= player_add;
              opponent_hit_reg   <= opponent_add;
              lock_cnt_reg       <= '0;
            end
          end

          LOCKOUT: begin
            // A touch in the final window cycle still counts toward the
            // win decision taken in that same cycle.
            player_score_out   <= player_score_next;
            opponent_score_out <= opponent_score_next;
            player_hit_reg     <= player_hit_reg | player_add;
            opponent_hit_reg   <= opponent_hit_reg | opponent_add;
            if (lock_cnt_reg == LOCK_LAST) begin
              lock_cnt_reg   <= '0;
              fencing_en_out <= 1'b0;
              if (player_reached || opponent_reached) begin
                state_reg  <= GAME_OVER;
                winner_out <= {opponent_reached, player_reached};
              end else begin
                state_reg     <= COUNTDOWN;
                tick_cnt_reg  <= '0;
                countdown_out <= CD_LOAD;
              end
            end else begin
              lock_cnt_reg <= lock_cnt_reg + 1'b1;
            end
          end

          default: begin
            state_reg      <= IDLE;
            fencing_en_out <= 1'b0;
            countdown_out  <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bout_controller.sv
// -----------------------------------------------------------------------------
// tb_bout_controller
//   Scoreboard bench for bout_controller. The stimulus process drives inputs,
//   advances a behavioural model (phases with remaining-cycle budgets) and
//   pushes each expected output snapshot, stamped with the sample time at which
//   it must first appear. A monitor samples the DUT on falling edges and pops
//   one entry whenever the DUT outputs change.
// -----------------------------------------------------------------------------
module tb_bout_controller;

  localparam int TICK = 4;
  localparam int CDT  = 3;
  localparam int LOCK = 5;
  localparam int WIN  = 2;

  logic       clk_pixel_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       start_in = 1'b0;
  logic       abort_in = 1'b0;
  logic       player_scored_in = 1'b0;
  logic       opponent_scored_in = 1'b0;
  logic       score_valid_in = 1'b0;
  logic [2:0] phase_out;
  logic       fencing_en_out;
  logic [1:0] countdown_out;
  logic       round_start_out;
  logic [3:0] player_score_out;
  logic [3:0] opponent_score_out;
  logic [1:0] winner_out;

  always #5 clk_pixel_in = ~clk_pixel_in;

  bout_controller #(
    .TICK_CYCLES(TICK),
    .COUNTDOWN_TICKS(CDT),
    .LOCKOUT_CYCLES(LOCK),
    .WIN_SCORE(WIN)
  ) dut (
    .clk_pixel_in(clk_pixel_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .abort_in(abort_in),
    .player_scored_in(player_scored_in),
    .opponent_scored_in(opponent_scored_in),
    .score_valid_in(score_valid_in),
    .phase_out(phase_out),
    .fencing_en_out(fencing_en_out),
    .countdown_out(countdown_out),
    .round_start_out(round_start_out),
    .player_score_out(player_score_out),
    .opponent_score_out(opponent_score_out),
    .winner_out(winner_out)
  );

  logic [16:0] dut_vec;
  assign dut_vec = {phase_out, fencing_en_out, countdown_out, round_start_out,
                    player_score_out, opponent_score_out, winner_out};

  typedef struct {
    time         t;
    logic [16:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model: phase number plus cycles left in the current phase.
  int   m_phase = 0;
  int   m_rem = 0;
  int   m_ps = 0;
  int   m_os = 0;
  int   m_win = 0;
  logic m_phit = 1'b0;
  logic m_ohit = 1'b0;
  logic m_rs = 1'b0;
  logic [16:0] last_exp = '0;

  function automatic logic [16:0] model_vec();
    logic [2:0] ph;
    logic       fen;
    logic [1:0] cd;
    ph  = 3'(m_phase);
    fen = (m_phase == 2) || (m_phase == 3);
    cd  = (m_phase == 1) ? 2'((m_rem + TICK - 1) / TICK) : 2'd0;
    return {ph, fen, cd, m_rs, 4'(m_ps), 4'(m_os), 2'(m_win)};
  endfunction

  task automatic push_expected(input time t);
    logic [16:0] v;
    v = model_vec();
    if (v !== last_exp) begin
      exp_q.push_back('{t, v});
      last_exp = v;
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_rem = 0; m_ps = 0; m_os = 0; m_win = 0;
    m_phit = 1'b0; m_ohit = 1'b0; m_rs = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic a, input logic p,
                            input logic o, input logic v);
    m_rs = 1'b0;
    if (a) begin
      m_phase = 0;
      m_rem   = 0;
    end else begin
      case (m_phase)
        0, 4: if (s) begin
          m_ps = 0; m_os = 0; m_win = 0;
          m_phase = 1; m_rem = CDT * TICK;
        end
        1: begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_phase = 2; m_rs = 1'b1; m_phit = 1'b0; m_ohit = 1'b0;
          end
        end
        2: if (v && (p || o)) begin
          if (p) begin m_ps = (m_ps < 15) ? m_ps + 1 : 15; m_phit = 1'b1; end
          if (o) begin m_os = (m_os < 15) ? m_os + 1 : 15; m_ohit = 1'b1; end
          m_phase = 3; m_rem = LOCK;
        end
        3: begin
          if (v && p && !m_phit) begin m_ps = (m_ps < 15) ? m_ps + 1 : 15; m_phit = 1'b1; end
          if (v && o && !m_ohit) begin m_os = (m_os < 15) ? m_os + 1 : 15; m_ohit = 1'b1; end
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            if (m_ps >= WIN || m_os >= WIN) begin
              m_phase = 4;
              m_win = ((m_os >= WIN) ? 2 : 0) + ((m_ps >= WIN) ? 1 : 0);
            end else begin
              m_phase = 1; m_rem = CDT * TICK;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic check_now(input string name, input logic [16:0] act, input logic [16:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("vec %0d %s ok %h at %0t", vectors, name, act, $time);
    end
  endtask

  // One clock cycle of stimulus; called and returns on a falling edge.
  task automatic step(input logic s, input logic a, input logic p, input logic o, input logic v);
    start_in = s; abort_in = a; player_scored_in = p;
    opponent_scored_in = o; score_valid_in = v;
    @(posedge clk_pixel_in);
    model_step(s, a, p, o, v);
    push_expected($time + 5);
    @(negedge clk_pixel_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance until the model enters the requested phase (bounded).
  task automatic idle_until(input int ph);
    for (int i = 0; i < 40 && m_phase != ph; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic do_reset(input int hold);
    start_in = 1'b0; abort_in = 1'b0; player_scored_in = 1'b0;
    opponent_scored_in = 1'b0; score_valid_in = 1'b0;
    #2 rst_in = 1'b0;
    #1 check_now("async_reset", dut_vec, 17'h0);
    model_reset();
    push_expected($time + 7);
    repeat (hold) @(negedge clk_pixel_in);
    #2 rst_in = 1'b1;
    @(negedge clk_pixel_in);
  endtask

  // Monitor: one scoreboard entry per observed output change.
  initial begin : monitor
    logic [16:0] prev;
    logic [16:0] cur;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clk_pixel_in);
      cur = dut_vec;
      if (cur !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change: got %h expected no change at %0t", cur, $time);
        end else begin
          e = exp_q.pop_front();
          if (e.t != $time || e.v !== cur) begin
            miscompares++;
            $display("FAIL output_change: got %h at %0t expected %h at %0t", cur, $time, e.v, e.t);
          end else begin
            $display("vec %0d t=%0t phase=%0d fen=%0b cd=%0d rs=%0b score=%0d/%0d win=%0d",
                     vectors, $time, cur[16:14], cur[13], cur[12:11], cur[10],
                     cur[9:6], cur[5:2], cur[1:0]);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].t <= $time) begin
        vectors++;
        miscompares++;
        e = exp_q.pop_front();
        $display("FAIL missed_change: got %h expected %h at %0t", cur, e.v, e.t);
      end
      prev = cur;
    end
  end

  initial begin : stimulus
    #3 check_now("reset_state", dut_vec, 17'h0);
    repeat (2) @(negedge clk_pixel_in);
    #2 rst_in = 1'b1;
    @(negedge clk_pixel_in);

    // Countdown 3,2,1 then FENCING with round_start pulse.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_until(2);
    idle(2);

    // Double touch: player, opponent three cycles later -> 1/1, back to COUNTDOWN.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_until(1);
    idle_until(2);
    idle(1);

    // Both touch in one strobe at 1/1 -> 2/2, tie.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle_until(4);
    // Strobes in GAME_OVER ignored; unqualified touch ignored.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    // Restart clears scores; strobes in COUNTDOWN ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_until(2);
    idle(1);

    // Repeated player touches inside the window count once.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_until(1);
    idle_until(2);

    // Abort wins over a simultaneous start.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Reset in the middle of LOCKOUT, then strobes ignored until start.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_until(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    do_reset(3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);
    // Reset in the middle of COUNTDOWN.
    do_reset(2);
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset(2);
      end else begin
        step(logic'($urandom_range(0, 99) < 3),
             logic'($urandom_range(0, 199) == 0),
             logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 99) < 20));
      end
    end

    idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bout_controller.md
BOUT_CONTROLLER -- requirements
Module: bout_controller

Interface
REQ-001 Parameter TICK_CYCLES, default 74_250_000, clk_pixel_in cycles per countdown tick (1 s).
REQ-002 Parameter COUNTDOWN_TICKS, default 3, ticks spent in COUNTDOWN (1..3).
REQ-003 Parameter LOCKOUT_CYCLES, default 2_970_000, double-touch window length in cycles (40 ms).
REQ-004 Parameter WIN_SCORE, default 5, touches needed to win (1..15).
REQ-005 clk_pixel_in  input  1  sole clock; all state on rising edge.
REQ-006 rst_in  input  1  reset, asynchronous assert, active-low.
REQ-007 start_in  input  1  single-cycle pulse; starts a bout from IDLE or GAME_OVER.
REQ-008 abort_in  input  1  single-cycle pulse; returns to IDLE from any state.
REQ-009 player_scored_in  input  1  local fencer landed a touch; qualified by score_valid_in.
REQ-010 opponent_scored_in  input  1  remote fencer landed a touch; qualified by score_valid_in.
REQ-011 score_valid_in  input  1  strobe qualifying both scored inputs.
REQ-012 phase_out  output  3  0 IDLE, 1 COUNTDOWN, 2 FENCING, 3 LOCKOUT, 4 GAME_OVER.
REQ-013 fencing_en_out  output  1  high in FENCING and LOCKOUT; gates block/lunge handling.
REQ-014 countdown_out  output  2  ticks remaining while in COUNTDOWN, else 0.
REQ-015 round_start_out  output  1  one-cycle pulse on each COUNTDOWN->FENCING transition.
REQ-016 player_score_out  output  4  local touch count.
REQ-017 opponent_score_out  output  4  remote touch count.
REQ-018 winner_out  output  2  00 none, 01 player, 10 opponent, 11 tie; valid in GAME_OVER.

Function
REQ-019 All outputs registered; a state transition appears on phase_out one cycle after the triggering input or counter terminal count.
REQ-020 IDLE: outputs held; start_in clears both scores and winner_out, loads tick counter and countdown_out=COUNTDOWN_TICKS, enters COUNTDOWN.
REQ-021 COUNTDOWN: tick counter counts TICK_CYCLES cycles; on each terminal count countdown_out decrements; when it would reach 0, enter FENCING and pulse round_start_out.
REQ-022 FENCING: score_valid_in with either scored input high increments that side's score (both if both high, same cycle), loads lockout counter with LOCKOUT_CYCLES, enters LOCKOUT; scored inputs without score_valid_in ignored.
REQ-023 LOCKOUT: a valid touch by the side not yet scored this round increments that side once (double touch); repeat touches by an already-scored side ignored; each side scores at most once per round.
REQ-024 LOCKOUT exit after exactly LOCKOUT_CYCLES cycles: if either score >= WIN_SCORE enter GAME_OVER, else reload countdown and enter COUNTDOWN.
REQ-025 winner_out on GAME_OVER entry: 01 if only player reached WIN_SCORE, 10 if only opponent, 11 if both.
REQ-026 Scores saturate at 15; never wrap.
REQ-027 score_valid_in in IDLE, COUNTDOWN, GAME_OVER is ignored; scores unchanged.
REQ-028 GAME_OVER: outputs held; start_in behaves as in IDLE (REQ-020).
REQ-029 abort_in has priority over start_in and over all same-cycle events; enters IDLE, scores retained, counters cleared.
REQ-030 start_in in COUNTDOWN, FENCING or LOCKOUT is ignored.
REQ-031 Counters sized by $clog2 of their parameters; no truncation at default values.

Reset
REQ-032 rst_in low asynchronously forces IDLE, all counters 0, all outputs 0, irrespective of clock.
REQ-033 Reset asserted mid-LOCKOUT or mid-COUNTDOWN discards the pending round; after release, the block waits for start_in.

Verification (TICK_CYCLES=4, COUNTDOWN_TICKS=3, LOCKOUT_CYCLES=5, WIN_SCORE=2)
REQ-034 Reset release, start_in pulse -> countdown_out 3,2,1 each for 4 cycles, then phase_out=2 and one round_start_out pulse, fencing_en_out=1.
REQ-035 In FENCING, player touch valid; opponent touch valid 3 cycles later -> scores 1/1, phase LOCKOUT for 5 cycles, then COUNTDOWN.
REQ-036 Player touch, then 3 more player touches within lockout -> player_score_out=1 only; opponent 0.
REQ-037 Scores 1/1, both scored_in high with one score_valid_in -> scores 2/2, GAME_OVER, winner_out=11; next start_in -> scores 0/0, COUNTDOWN.
REQ-038 score_valid_in pulses during COUNTDOWN and GAME_OVER -> scores unchanged; abort_in with simultaneous start_in in FENCING -> IDLE.
REQ-039 rst_in low mid-LOCKOUT with no clock edge -> all outputs 0 immediately; post-release score_valid_in ignored until start_in.
